// File: rtl/boot_loader_if.sv
// Byte-stream input and memory write/status outputs of the boot loader.
// master = byte source / system side, slave = the loader itself.
interface boot_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 12
);
  logic [DATA_WIDTH-1:0] rx_dat;
  logic                  rx_vld;
  logic                  rx_rdy;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dat;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;

  modport master (
    output rx_dat, rx_vld,
    input  rx_rdy, mem_wr_en, mem_addr, mem_dat, cpu_hold, load_done, load_error
  );

  modport slave (
    input  rx_dat, rx_vld,
    output rx_rdy, mem_wr_en, mem_addr, mem_dat, cpu_hold, load_done, load_error
  );
endinterface

// File: rtl/boot_loader.sv
// Frame loader: A5/addr/len/data/cksum bytes -> memory writes; CPU held until a good checksum.
// Write strobe 1 cycle after data-byte accept; rx_rdy low only in the one-cycle WRITE state.
module boot_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit HOLD_ON_RESET  = 1'b1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  boot_loader_if.slave bl_if
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]         TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] SYNC     = DATA_WIDTH'(8'hA5);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, addr_q;
  logic [DATA_WIDTH-1:0]   hdr_hi_q, sum_q, din_q;
  logic [2*DATA_WIDTH-1:0] remain_q;
  logic [TW-1:0]           timer_q;
  logic                    rdy_q, wr_en_q, hold_q, done_q, err_q;

  logic                    accept;
  logic [2*DATA_WIDTH-1:0] hdr_word;

  assign accept   = bl_if.rx_vld & rdy_q;
  assign hdr_word = {hdr_hi_q, bl_if.rx_dat};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cur_addr_q <= '0;
      addr_q     <= '0;
      hdr_hi_q   <= '0;
      sum_q      <= '0;
      din_q      <= '0;
      remain_q   <= '0;
      timer_q    <= '0;
      rdy_q      <= 1'b1;
      wr_en_q    <= 1'b0;
      hold_q     <= HOLD_ON_RESET;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_IDLE || accept) timer_q <= '0;
      else                             timer_q <= timer_q + 1'b1;

      case (state_q)
        S_IDLE: if (accept && bl_if.rx_dat == SYNC) begin
          hold_q  <= 1'b1;
          err_q   <= 1'b0;
          sum_q   <= '0;
          state_q <= S_ADDR_HI;
        end
        S_ADDR_HI: if (accept) begin
          hdr_hi_q <= bl_if.rx_dat;
          state_q  <= S_ADDR_LO;
        end
        S_ADDR_LO: if (accept) begin
          // upper address bits beyond the memory width are dropped here
          cur_addr_q <= hdr_word[ADDR_WIDTH-1:0];
          state_q    <= S_LEN_HI;
        end
        S_LEN_HI: if (accept) begin
          hdr_hi_q <= bl_if.rx_dat;
          state_q  <= S_LEN_LO;
        end
        S_LEN_LO: if (accept) begin
          remain_q <= hdr_word;
          state_q  <= (hdr_word == '0) ? S_CHECK : S_DATA;
        end
        S_DATA: if (accept) begin
          din_q    <= bl_if.rx_dat;
          addr_q   <= cur_addr_q;
          wr_en_q  <= 1'b1;
          rdy_q    <= 1'b0;
          sum_q    <= sum_q + bl_if.rx_dat;
          remain_q <= remain_q - 1'b1;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          wr_en_q    <= 1'b0;
          rdy_q      <= 1'b1;
          cur_addr_q <= cur_addr_q + 1'b1;
          state_q    <= (remain_q == '0) ? S_CHECK : S_DATA;
        end
        S_CHECK: if (accept) begin
          if (bl_if.rx_dat == sum_q) begin
            done_q <= 1'b1;
            hold_q <= 1'b0;
          end else begin
            err_q  <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      // inter-byte timeout overrides whatever the frame states decided
      if (state_q != S_IDLE && !accept && timer_q == TMO_LAST) begin
        state_q <= S_IDLE;
        err_q   <= 1'b1;
        wr_en_q <= 1'b0;
        rdy_q   <= 1'b1;
        timer_q <= '0;
      end
    end
  end

  assign bl_if.rx_rdy     = rdy_q;
  assign bl_if.mem_wr_en  = wr_en_q;
  assign bl_if.mem_addr   = addr_q;
  assign bl_if.mem_dat    = din_q;
  assign bl_if.cpu_hold   = hold_q;
  assign bl_if.load_done  = done_q;
  assign bl_if.load_error = err_q;
endmodule

// File: tb/tb_boot_loader.sv
// Randomized and directed frames against a queue-based model of the frame format.
module tb_boot_loader;
  localparam int AW    = 12;
  localparam int MSIZE = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boot_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(AW)) bus ();

  boot_loader #(
    .DATA_WIDTH(8), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16), .HOLD_ON_RESET(1'b1)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bl_if(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int done_cnt = 0;
  int inv_bad  = 0;
  logic [19:0] got_wr[$];
  logic [7:0]  pl[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // passive observer: collects writes, done pulses, and rdy/wr_en exclusivity
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) got_wr.push_back({bus.mem_addr, bus.mem_dat});
    if (bus.load_done === 1'b1) done_cnt++;
    if (bus.rx_rdy === bus.mem_wr_en) inv_bad++;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int guard = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.rx_vld = 1'b1;
    bus.rx_dat = b;
    while (bus.rx_rdy !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8) chk("rx_rdy_stuck", 32'(bus.rx_rdy), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_vld = 1'b0;
  endtask

  task automatic send_junk(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      send_byte(b, 0);
    end
  endtask

  // model: write i lands at (addr+i) mod 2**AW; good iff cksum == sum(data) mod 256
  task automatic run_frame(input logic [15:0] addr, input bit bad, input int max_gap, input string tag);
    int len = pl.size();
    int sum = 0;
    logic [7:0] ck;
    bit good;
    int ea;
    for (int i = 0; i < len; i++) sum += int'(pl[i]);
    ck = bad ? 8'(sum + 1) : 8'(sum);
    good = !bad;
    got_wr.delete();
    done_cnt = 0;
    send_byte(8'hA5, $urandom_range(0, max_gap));
    chk({tag, "_sync_hold"}, 32'(bus.cpu_hold), 32'd1);
    chk({tag, "_sync_err"}, 32'(bus.load_error), 32'd0);
    send_byte(addr[15:8], $urandom_range(0, max_gap));
    send_byte(addr[7:0], $urandom_range(0, max_gap));
    send_byte(8'(len >> 8), $urandom_range(0, max_gap));
    send_byte(8'(len), $urandom_range(0, max_gap));
    for (int i = 0; i < len; i++) begin
      ea = (int'(addr) + i) % MSIZE;
      send_byte(pl[i], $urandom_range(0, max_gap));
      if (i < 3 || i == len - 1) begin
        chk({tag, "_wr_en"}, 32'(bus.mem_wr_en), 32'd1);
        chk({tag, "_wr_addr"}, 32'(bus.mem_addr), 32'(ea));
        chk({tag, "_wr_dat"}, 32'(bus.mem_dat), 32'(pl[i]));
      end
    end
    chk({tag, "_pre_ck_hold"}, 32'(bus.cpu_hold), 32'd1);
    send_byte(ck, $urandom_range(0, max_gap));
    chk({tag, "_done"}, 32'(bus.load_done), 32'(good));
    chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(!good));
    chk({tag, "_err"}, 32'(bus.load_error), 32'(!good));
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'(good));
    chk({tag, "_n_writes"}, 32'(got_wr.size()), 32'(len));
    for (int i = 0; i < len && i < got_wr.size(); i++) begin
      ea = (int'(addr) + i) % MSIZE;
      if (got_wr[i] !== {12'(ea), pl[i]})
        chk({tag, "_write_log"}, 32'(got_wr[i]), 32'({12'(ea), pl[i]}));
    end
  endtask

  initial begin
    bus.rx_vld = 1'b0;
    bus.rx_dat = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(bus.rx_rdy), 32'd1);
    chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_din", 32'(bus.mem_dat), 32'd0);
    chk("rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_done", 32'(bus.load_done), 32'd0);
    chk("rst_err", 32'(bus.load_error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    pl = '{8'h11, 8'h22, 8'h33};
    run_frame(16'h0200, 1'b0, 0, "t1");
    run_frame(16'h0200, 1'b1, 0, "t2_bad");
    run_frame(16'h0200, 1'b0, 2, "t2_good");

    pl = '{8'hAA, 8'hBB};
    run_frame(16'h0FFF, 1'b0, 1, "t3_wrap");

    got_wr.delete();
    send_byte(8'h00, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h5A, 0);
    chk("t4_junk_writes", 32'(got_wr.size()), 32'd0);
    chk("t4_junk_hold", 32'(bus.cpu_hold), 32'd0);
    pl.delete();
    run_frame(16'h0100, 1'b0, 0, "t4_zero");

    // inter-byte timeout: 16 idle cycles after the last header byte
    send_byte(8'hA5, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("t5_err_before", 32'(bus.load_error), 32'd0);
    @(posedge clk);
    #1;
    chk("t5_err", 32'(bus.load_error), 32'd1);
    chk("t5_hold", 32'(bus.cpu_hold), 32'd1);
    got_wr.delete();
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    repeat (2) @(negedge clk);
    chk("t5_discard_writes", 32'(got_wr.size()), 32'd0);
    chk("t5_err_sticky", 32'(bus.load_error), 32'd1);

    // reset during the write of the 2nd data byte
    got_wr.delete();
    done_cnt = 0;
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    chk("t6_rst_hold", 32'(bus.cpu_hold), 32'd1);
    chk("t6_rst_addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h33, 0);
    send_byte(8'h66, 0);
    repeat (3) @(negedge clk);
    chk("t6_writes", 32'(got_wr.size()), 32'd2);
    chk("t6_done", 32'(done_cnt), 32'd0);
    chk("t6_hold", 32'(bus.cpu_hold), 32'd1);

    for (int f = 0; f < 10; f++) begin
      send_junk($urandom_range(0, 3));
      pl.delete();
      for (int i = 0; i < $urandom_range(1, 24); i++) pl.push_back(8'($urandom_range(0, 255)));
      run_frame(16'($urandom_range(0, 65535)), $urandom_range(0, 2) == 0, 3, "rnd");
    end

    // length above the memory size wraps and overwrites; not an error
    pl.delete();
    for (int i = 0; i < MSIZE + 4; i++) pl.push_back(8'($urandom_range(0, 255)));
    run_frame(16'hFFFE, 1'b0, 0, "long_wrap");

    chk("rdy_only_low_in_write", 32'(inv_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
